// File: rtl/denoise_frame_sequencer.sv
// Frame-level gate in front of the noise-reduction core: locks onto SOF, regenerates
// tuser/tlast from programmed width/height, and reports framing errors and completed frames.
module denoise_frame_sequencer #(
  parameter int DATA_WIDTH = 40,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_enable,
  input  logic [CNT_W-1:0]      cfg_width,
  input  logic [CNT_W-1:0]      cfg_height,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tuser,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_eol_early,
  output logic                  err_eol_late,
  output logic                  err_sof_early
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_x, r_y, r_w, r_h, r_frame_cnt;
  logic [CNT_W-1:0] w_x_next, w_y_next, w_w_next, w_h_next, w_frame_cnt_next;
  logic             r_frame_done, w_frame_done_next;
  logic             r_err_eol_early, r_err_eol_late, r_err_sof_early;
  logic             w_set_eol_early, w_set_eol_late, w_set_sof_early;
  logic             w_start, w_complete;

  logic w_hs, w_cfg_ok, w_x_last, w_y_last, w_at_origin, w_start_wlast, w_start_hlast;

  assign w_hs          = s_tvalid & s_tready;
  assign w_cfg_ok      = cfg_enable && (cfg_width != '0) && (cfg_height != '0);
  // Shadows are nonzero whenever ACTIVE, so the -1 never wraps where it matters.
  assign w_x_last      = (r_x == r_w - ONE);
  assign w_y_last      = (r_y == r_h - ONE);
  assign w_at_origin   = (r_x == '0) && (r_y == '0);
  assign w_start_wlast = (cfg_width == ONE);
  assign w_start_hlast = (cfg_height == ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_w             <= '0;
      r_h             <= '0;
      r_frame_cnt     <= '0;
      r_frame_done    <= 1'b0;
      r_err_eol_early <= 1'b0;
      r_err_eol_late  <= 1'b0;
      r_err_sof_early <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_x             <= w_x_next;
      r_y             <= w_y_next;
      r_w             <= w_w_next;
      r_h             <= w_h_next;
      r_frame_cnt     <= w_frame_cnt_next;
      r_frame_done    <= w_frame_done_next;
      // A set in the same cycle as err_clr wins.
      r_err_eol_early <= w_set_eol_early | (r_err_eol_early & ~err_clr);
      r_err_eol_late  <= w_set_eol_late  | (r_err_eol_late  & ~err_clr);
      r_err_sof_early <= w_set_sof_early | (r_err_sof_early & ~err_clr);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_w_next          = r_w;
    w_h_next          = r_h;
    w_frame_cnt_next  = r_frame_cnt;
    w_frame_done_next = 1'b0;
    w_set_eol_early   = 1'b0;
    w_set_eol_late    = 1'b0;
    w_set_sof_early   = 1'b0;
    w_start           = 1'b0;
    w_complete        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cfg_ok) w_state_next = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (w_hs && s_tuser) begin
          w_set_eol_early = s_tlast & ~w_start_wlast;
          w_set_eol_late  = ~s_tlast & w_start_wlast;
          w_start         = 1'b1;
        end else if (!cfg_enable && !(s_tvalid && s_tuser)) begin
          w_state_next = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (w_hs) begin
          w_set_eol_early = s_tlast & ~w_x_last;
          w_set_eol_late  = ~s_tlast & w_x_last;
          if (s_tuser && !w_at_origin) begin
            w_set_sof_early = 1'b1;
            w_start         = 1'b1;
          end else if (w_x_last) begin
            w_x_next = '0;
            if (w_y_last) begin
              w_y_next   = '0;
              w_complete = 1'b1;
            end else begin
              w_y_next = r_y + ONE;
            end
          end else begin
            w_x_next = r_x + ONE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Accepting a SOF counts it as pixel (0,0) of a freshly latched geometry.
    if (w_start) begin
      w_w_next     = cfg_width;
      w_h_next     = cfg_height;
      w_state_next = S_ACTIVE;
      if (!w_start_wlast) begin
        w_x_next = ONE;
        w_y_next = '0;
      end else if (!w_start_hlast) begin
        w_x_next = '0;
        w_y_next = ONE;
      end else begin
        w_x_next   = '0;
        w_y_next   = '0;
        w_complete = 1'b1;
      end
    end

    if (w_complete) begin
      w_frame_done_next = 1'b1;
      w_frame_cnt_next  = r_frame_cnt + ONE;
      w_state_next      = cfg_enable ? S_WAIT_SOF : S_IDLE;
    end
  end

  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tuser  = 1'b0;
    m_tlast  = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_WAIT_SOF: begin
        s_tready = s_tuser ? m_tready : 1'b1;
        m_tvalid = s_tvalid & s_tuser;
        m_tuser  = 1'b1;
        m_tlast  = w_start_wlast;
      end
      S_ACTIVE: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tuser  = w_at_origin | s_tuser;
        m_tlast  = w_x_last;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_tdata       = s_tdata;
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;
  assign err_eol_early = r_err_eol_early;
  assign err_eol_late  = r_err_eol_late;
  assign err_sof_early = r_err_sof_early;

endmodule

// File: tb/tb_denoise_frame_sequencer.sv
// Directed frame scenarios followed by a randomized run, all checked against a
// pixel-index reference model of the frame sequencer.
module tb_denoise_frame_sequencer;
  localparam int DW = 40;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast;
  logic          m_tready = 1'b1;
  logic          busy, frame_done;
  logic [CW-1:0] frame_cnt;
  logic          err_eol_early, err_eol_late, err_sof_early;

  denoise_frame_sequencer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .err_clr(err_clr), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late), .err_sof_early(err_sof_early)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle, 1=hunting for SOF, 2=inside a frame at pixel index m_pos.
  int m_mode = 0, m_pos = 0, m_w = 0, m_h = 0, m_cnt = 0;
  bit m_done = 0, m_ee = 0, m_el = 0, m_es = 0;
  bit dut_hs = 0;
  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  bit stall_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_finish_frame();
    m_pos  = 0;
    m_done = 1;
    m_cnt  = (m_cnt + 1) % 65536;
    m_mode = cfg_enable ? 1 : 0;
    $display("frame complete: frame_cnt=%0d (%0dx%0d)", m_cnt, m_w, m_h);
  endtask

  task automatic model_begin_frame();
    m_w    = int'(cfg_width);
    m_h    = int'(cfg_height);
    m_pos  = 1;
    m_mode = 2;
    if (m_w * m_h == 1) model_finish_frame();
  endtask

  task automatic step(input bit v, input bit u, input bit l, input bit mr);
    logic [63:0] rnd;
    bit er, ev, eu, elst, eb, hs, se, sl, ss, col_last;
    @(negedge clk);
    rnd = {$urandom, $urandom};
    s_tdata = rnd[DW-1:0];
    s_tvalid = v; s_tuser = u; s_tlast = l; m_tready = mr;
    #1;
    er = 0; ev = 0; eu = 0; elst = 0; eb = 0;
    if (m_mode == 1) begin
      er = u ? mr : 1'b1; ev = v & u; eu = 1; elst = (cfg_width == 1);
    end else if (m_mode == 2) begin
      er = mr; ev = v; eu = (m_pos == 0) || u; elst = (m_pos % m_w == m_w - 1); eb = 1;
    end
    check("s_tready", 64'(s_tready), 64'(er));
    check("m_tvalid", 64'(m_tvalid), 64'(ev));
    check("m_tuser",  64'(m_tuser),  64'(eu));
    check("m_tlast",  64'(m_tlast),  64'(elst));
    check("busy",     64'(busy),     64'(eb));
    check("m_tdata",  64'(m_tdata),  64'(s_tdata));
    dut_hs = s_tready & v;
    hs = er & v;
    @(posedge clk);
    #1;
    cyc++;
    m_done = 0; se = 0; sl = 0; ss = 0;
    case (m_mode)
      0: if (cfg_enable && cfg_width != 0 && cfg_height != 0) m_mode = 1;
      1: begin
        if (hs && u) begin
          se = l && (cfg_width != 1);
          sl = !l && (cfg_width == 1);
          model_begin_frame();
        end else if (!cfg_enable && !(v && u)) begin
          m_mode = 0;
        end
      end
      default: begin
        if (hs) begin
          col_last = (m_pos % m_w == m_w - 1);
          se = l && !col_last;
          sl = !l && col_last;
          if (u && m_pos != 0) begin
            ss = 1;
            model_begin_frame();
          end else begin
            m_pos++;
            if (m_pos == m_w * m_h) model_finish_frame();
          end
        end
      end
    endcase
    m_ee = se | (m_ee & !err_clr);
    m_el = sl | (m_el & !err_clr);
    m_es = ss | (m_es & !err_clr);
    check("frame_done",    64'(frame_done),    64'(m_done));
    check("frame_cnt",     64'(frame_cnt),     64'(m_cnt));
    check("err_eol_early", 64'(err_eol_early), 64'(m_ee));
    check("err_eol_late",  64'(err_eol_late),  64'(m_el));
    check("err_sof_early", 64'(err_sof_early), 64'(m_es));
  endtask

  // Offers one beat until the DUT takes it; m_tready follows 1,0,0,1 when stalling.
  task automatic beat(input bit u, input bit l);
    int tries;
    bit mr;
    tries = 0;
    do begin
      mr = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      step(1'b1, u, l, mr);
      tries++;
    end while (!dut_hs && tries < 40);
    check("beat_accepted", 64'(dut_hs), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    m_mode = 0; m_pos = 0; m_w = 0; m_h = 0; m_cnt = 0;
    m_done = 0; m_ee = 0; m_el = 0; m_es = 0;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_errs", 64'({err_eol_early, err_eol_late, err_sof_early}), 64'd0);
    @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rstn = 1'b1;
  endtask

  task automatic frame_4x2();
    for (int i = 0; i < 8; i++) beat(i == 0, (i % 4) == 3);
  endtask

  initial begin
    bit v, u, l, mr;
    int col;

    // Basic 4x2 frame.
    do_reset();
    cfg_width = 4; cfg_height = 2; cfg_enable = 1;
    step(0, 0, 0, 1);
    frame_4x2();
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Leading non-SOF beats are swallowed.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) beat(0, 0);
    check("t2_cnt_before", 64'(frame_cnt), 64'd0);
    frame_4x2();
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);

    // Early and missing tlast, then clear.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) beat(i == 0, (i == 2) || (i == 7));
    check("t3_eol_early", 64'(err_eol_early), 64'd1);
    check("t3_eol_late",  64'(err_eol_late),  64'd1);
    err_clr = 1;
    step(0, 0, 0, 1);
    err_clr = 0;
    check("t3_cleared", 64'({err_eol_early, err_eol_late}), 64'd0);

    // Backpressure from the core.
    do_reset();
    step(0, 0, 0, 1);
    stall_mode = 1;
    frame_4x2();
    stall_mode = 0;
    check("t4_frame_cnt", 64'(frame_cnt), 64'd1);

    // SOF arriving mid-frame restarts the frame.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) beat(i == 0, (i % 4) == 3);
    beat(1, 0);
    check("t5_sof_early", 64'(err_sof_early), 64'd1);
    for (int p = 1; p < 8; p++) beat(0, (p % 4) == 3);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);

    // Enable dropped mid-frame: the frame still completes, then idle.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) beat(i == 0, 0);
    cfg_enable = 0;
    for (int i = 3; i < 8; i++) beat(0, (i % 4) == 3);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    step(1, 1, 0, 1);
    check("t6_busy", 64'(busy), 64'd0);

    // Reset in the middle of a frame with a sticky error set.
    cfg_enable = 1;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) beat(i == 0, i == 1);
    s_tvalid = 1;
    do_reset();

    // Zero width keeps the block idle.
    cfg_width = 0;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    check("t8_zero_idle", 64'(busy), 64'd0);

    // Randomized traffic.
    cfg_width = 3; cfg_height = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) cfg_enable = ($urandom_range(0, 3) != 0);
      if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
        cfg_width  = CW'($urandom_range(1, 5));
        cfg_height = CW'($urandom_range(1, 3));
      end
      err_clr = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      u  = (m_mode == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) < 2);
      col = (m_mode == 2) ? (m_pos % m_w) : 0;
      l  = (m_mode == 2) ? (col == m_w - 1) : (cfg_width == 1);
      if ($urandom_range(0, 9) == 0) l = !l;
      mr = ($urandom_range(0, 9) < 7);
      step(v, u, l, mr);
    end
    err_clr = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
